// File: rtl/scmp_dly_pkg.sv
// Shared definitions for the SC/MP DLY sequencer.
//   - ALU op-code macros (SZ_ALU_OP, ALU_OP_DEC, ALU_OP_PASS). These carry the
//     same values as the microcode header scmp_micrcode.vh. They are guarded so
//     that whichever definition is seen first wins.
//   - state enum, tick-counter width and per-step tick count.
`ifndef SZ_ALU_OP
`define SZ_ALU_OP 4
`endif
`ifndef ALU_OP_PASS
`define ALU_OP_PASS 4'h0
`endif
`ifndef ALU_OP_DEC
`define ALU_OP_DEC 4'h5
`endif

package scmp_dly_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LOOP,
    ST_FIN,
    ST_DONE
  } dly_state_e;

  localparam int CNT_W          = 8;
  localparam int DLY_STEP_TICKS = 2;

  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(DLY_STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

endpackage

// File: rtl/scmp_dly_seq.sv
// scmp_dly_seq -- sequencer for the SC/MP DLY instruction.
// Holds the CPU for PRE_CYCLES + 2*AC + 514*disp ticks, counting AC (and a
// private copy of the displacement) down through the shared external ALU.
// Ends with AC = 8'hFF.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ce_i       microcycle tick enable; nothing advances without it
//   start_i    begin DLY (sampled in IDLE on a tick)
//   ac_i       AC value at start
//   disp_i     displacement at start
//   alu_op_o   ALU operation select (pass while idle, DEC on decrement ticks)
//   alu_a_o    ALU A operand (AC copy or displacement copy, 0 while idle)
//   alu_res_i  ALU result
//   ac_o       AC write-back data (straight from alu_res_i)
//   ac_we_o    AC write strobe, qualified by ce_i
//   busy_o     sequencer owns the ALU and the AC write port
//   done_o     one-clock completion pulse
//   abort_i    (only with SCMP_DLY_ABORT_EN) drop back to IDLE next clock
//
// Build option: define SCMP_DLY_ABORT_EN to add the abort_i port.
//
// state | meaning
// IDLE  | waiting for start_i; ALU driven with pass/0
// PRE   | fixed overhead, PRE_CYCLES-2 ticks
// LOOP  | 2-tick steps; DEC AC, or DEC disp copy (then AC wraps next step)
// FIN   | final DEC of AC 00->FF, written on its last tick
// DONE  | done_o pulse for one clock, then IDLE
module scmp_dly_seq
  import scmp_dly_pkg::*;
#(
  parameter int PRE_CYCLES = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce_i,
  input  logic                  start_i,
  input  logic [7:0]            ac_i,
  input  logic [7:0]            disp_i,
  output logic [`SZ_ALU_OP-1:0] alu_op_o,
  output logic [7:0]            alu_a_o,
  input  logic [7:0]            alu_res_i,
  output logic [7:0]            ac_o,
  output logic                  ac_we_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef SCMP_DLY_ABORT_EN
  ,
  input  logic                  abort_i
`endif
);

  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 3);

  dly_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            ac_q, ac_d;
  logic [7:0]            disp_q, disp_d;
  logic                  wrap_q, wrap_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ac_wr_q, ac_wr_d;
  logic [`SZ_ALU_OP-1:0] alu_op_q, alu_op_d;
  logic [7:0]            alu_a_q, alu_a_d;
  logic                  abort;
  logic                  op_dec;
  logic                  sel_ac;

`ifdef SCMP_DLY_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ac_d    = ac_q;
    disp_d  = disp_q;
    wrap_d  = wrap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ce_i && start_i) begin
          ac_d    = ac_i;
          disp_d  = disp_i;
          wrap_d  = 1'b0;
          cnt_d   = PRE_LOAD;
          busy_d  = 1'b1;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        if (ce_i) begin
          if (cnt_q == '0) begin
            cnt_d   = STEP_LOAD;
            state_d = ST_LOOP;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_LOOP: begin
        if (ce_i) begin
          if (cnt_q != '0) begin
            // The exit tick doubles as the first FIN tick, so FIN only
            // needs its write tick afterwards.
            if (cnt_q == STEP_LOAD && ac_q == 8'h00 && disp_q == 8'h00 && !wrap_q) begin
              cnt_d   = '0;
              state_d = ST_FIN;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end else begin
            // wrap_q forces the AC 00->FF step right after a disp decrement
            if (ac_q != 8'h00 || wrap_q) begin
              ac_d   = alu_res_i;
              wrap_d = 1'b0;
            end else begin
              disp_d = alu_res_i;
              wrap_d = 1'b1;
            end
            cnt_d = STEP_LOAD;
          end
        end
      end
      ST_FIN: begin
        if (ce_i) begin
          ac_d    = alu_res_i;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort && busy_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ac_d    = ac_q;
      disp_d  = disp_q;
      wrap_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end

    // ALU drive is registered from the next state so it is stable for the
    // whole decrement phase, however many clocks ce_i keeps it waiting.
    op_dec   = (state_d == ST_LOOP && cnt_d == '0) || (state_d == ST_FIN);
    sel_ac   = (state_d == ST_FIN) || (ac_d != 8'h00) || wrap_d;
    alu_op_d = op_dec ? `ALU_OP_DEC : `ALU_OP_PASS;
    alu_a_d  = op_dec ? (sel_ac ? ac_d : disp_d) : 8'h00;
    ac_wr_d  = op_dec && sel_ac;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ac_q     <= 8'h00;
      disp_q   <= 8'h00;
      wrap_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ac_wr_q  <= 1'b0;
      alu_op_q <= `ALU_OP_PASS;
      alu_a_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ac_q     <= ac_d;
      disp_q   <= disp_d;
      wrap_q   <= wrap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ac_wr_q  <= ac_wr_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
    end
  end

  assign alu_op_o = alu_op_q;
  assign alu_a_o  = alu_a_q;
  assign ac_o     = alu_res_i;
  assign ac_we_o  = ac_wr_q & ce_i & ~abort;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
